// File: rtl/jtframe_rom_nslots.sv
// Fixed-priority N-slot ROM read arbiter in front of a 16-bit SDRAM burst port.
// Define JTFRAME_ROM_CACHE_EN to keep served data valid after a slot's cs falls.
module jtframe_rom_nslots #(
  parameter int                  SLOTS   = 2,
  parameter int                  DW      = 8,
  parameter int                  AW      = 18,
  parameter logic [SLOTS*22-1:0] OFFSETS = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SLOTS-1:0]      slot_cs,
  input  logic [SLOTS*AW-1:0]   slot_addr,
  output logic [SLOTS*DW-1:0]   slot_dout,
  output logic [SLOTS-1:0]      slot_ok,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  output logic [21:0]           sdram_addr,
  input  logic                  data_dst,
  input  logic                  data_rdy,
  input  logic [15:0]           data_read
);
  localparam int IW = SLOTS > 1 ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  state_t            state;
  logic [AW-1:0]     addr_lat [SLOTS];
  logic [DW-1:0]     data_r   [SLOTS];
  logic [SLOTS-1:0]  valid;
  logic [SLOTS-1:0]  pending;
  logic [IW-1:0]     cur;
  logic              burst;
  logic              rdy_ok;
  logic              cap_done;
  logic [DW-1:0]     cap_word;
  logic              sel_valid;
  logic [IW-1:0]     sel_idx;
  logic [AW-1:0]     sel_raw;
  logic [21:0]       sel_addr;

  // Client address (DW units) to 16-bit SDRAM word address.
  function automatic logic [21:0] word_addr(input logic [AW-1:0] a);
    logic [AW:0] ext;
    ext = {1'b0, a};
    if (DW == 8)       ext = ext >> 1;
    else if (DW == 32) ext = ext << 1;
    return 22'(ext);
  endfunction

  // NOTE: every variable driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_ok   = '0;
    slot_dout = '0;
    pending   = '0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_raw   = '0;
    sel_addr  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      slot_ok[i]          = slot_cs[i] & valid[i] & (slot_addr[i*AW +: AW] == addr_lat[i]);
      pending[i]          = slot_cs[i] & ~slot_ok[i];
      slot_dout[i*DW +: DW] = data_r[i];
    end
    // Scan downwards so the lowest pending index wins.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
        sel_raw   = slot_addr[i*AW +: AW];
        sel_addr  = word_addr(slot_addr[i*AW +: AW]) + OFFSETS[i*22 +: 22];
      end
    end
  end

  // A word counts only at dst or on a rdy later in the same burst.
  assign rdy_ok = (state == WAIT_DATA) & data_rdy & (data_dst | burst);

  generate
    if (DW == 32) begin : g_dw32
      logic [15:0] low_word;
      logic        half;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          low_word <= '0;
          half     <= 1'b0;
        end else if (state != WAIT_DATA) begin
          half <= 1'b0;
        end else if (rdy_ok) begin
          low_word <= data_read;
          half     <= ~half;
        end
      end
      assign cap_word = {data_read, low_word};
      assign cap_done = rdy_ok & half;
    end else if (DW == 16) begin : g_dw16
      assign cap_word = data_read;
      assign cap_done = rdy_ok;
    end else begin : g_dw8
      assign cap_word = addr_lat[cur][0] ? data_read[15:8] : data_read[7:0];
      assign cap_done = rdy_ok;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff sees the pre-edge values of the others regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      valid      <= '0;
      cur        <= '0;
      burst      <= 1'b0;
      // NOTE: the per-slot arrays are reset explicitly because slot_dout must
      // read zero during reset; they are small registers, not RAM.
      for (int i = 0; i < SLOTS; i++) begin
        addr_lat[i] <= '0;
        data_r[i]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          burst <= 1'b0;
          if (sel_valid) begin
            addr_lat[sel_idx] <= sel_raw;
            valid[sel_idx]    <= 1'b0;
            cur               <= sel_idx;
            sdram_addr        <= sel_addr;
            sdram_req         <= 1'b1;
            state             <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          burst <= 1'b0;
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (data_dst) burst <= 1'b1;
          if (cap_done) begin
            data_r[cur] <= cap_word;
            valid[cur]  <= 1'b1;
            burst       <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef JTFRAME_ROM_CACHE_EN
`else
      // Without the cache, dropping cs forgets the slot's data.
      for (int i = 0; i < SLOTS; i++)
        if (!slot_cs[i]) valid[i] <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_jtframe_rom_nslots.sv
// Bench for jtframe_rom_nslots: a transaction-level model checks the 3-slot DW=8
// instance every cycle; a 2-slot DW=32 instance gets directed checks.
module tb_jtframe_rom_nslots;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam logic [65:0] A_OFF = {22'h3FFFF0, 22'h000040, 22'h000000};
  localparam logic [43:0] B_OFF = {22'h100000, 22'h000000};

  logic [2:0]  a_cs;   logic [53:0] a_addr; logic [23:0] a_dout; logic [2:0] a_ok;
  logic        a_req, a_ack, a_dst, a_rdy;  logic [21:0] a_saddr; logic [15:0] a_read;
  logic [1:0]  b_cs;   logic [35:0] b_addr; logic [63:0] b_dout; logic [1:0] b_ok;
  logic        b_req, b_ack, b_dst, b_rdy;  logic [21:0] b_saddr; logic [15:0] b_read;

  jtframe_rom_nslots #(.SLOTS(3), .DW(8), .AW(18), .OFFSETS(A_OFF)) dut_a (
    .clk(clk), .rst_n(rst_n), .slot_cs(a_cs), .slot_addr(a_addr), .slot_dout(a_dout),
    .slot_ok(a_ok), .sdram_req(a_req), .sdram_ack(a_ack), .sdram_addr(a_saddr),
    .data_dst(a_dst), .data_rdy(a_rdy), .data_read(a_read));

  jtframe_rom_nslots #(.SLOTS(2), .DW(32), .AW(18), .OFFSETS(B_OFF)) dut_b (
    .clk(clk), .rst_n(rst_n), .slot_cs(b_cs), .slot_addr(b_addr), .slot_dout(b_dout),
    .slot_ok(b_ok), .sdram_req(b_req), .sdram_ack(b_ack), .sdram_addr(b_saddr),
    .data_dst(b_dst), .data_rdy(b_rdy), .data_read(b_read));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pat(input logic [21:0] w);
    return 16'hA55A ^ {8'h00, w[7:0]};
  endfunction

  // Model: each slot remembers the address it was fetched for, its byte and a
  // valid flag; one fetch at a time, lowest-index needy slot first.
  logic        m_valid [3];
  logic [17:0] m_addr  [3];
  logic [7:0]  m_data  [3];
  logic        m_busy, m_dph, m_burst;
  int          m_slot;
  logic [21:0] m_word;

  function automatic logic m_ok(input int i);
    return a_cs[i] && m_valid[i] && (a_addr[i*18 +: 18] == m_addr[i]);
  endfunction

  function automatic int m_pick();
    for (int i = 0; i < 3; i++)
      if (a_cs[i] && !m_ok(i)) return i;
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
    end
    m_busy = 1'b0; m_dph = 1'b0; m_burst = 1'b0; m_slot = 0; m_word = '0;
  endtask

  initial begin
    int s;
    logic [21:0] t;
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else begin
        if (!m_busy) begin
          s = m_pick();
          if (s >= 0) begin
            m_busy = 1'b1; m_dph = 1'b0; m_slot = s;
            m_addr[s] = a_addr[s*18 +: 18];
            m_valid[s] = 1'b0;
            t = {4'b0, a_addr[s*18 +: 18]} >> 1;
            m_word = t + A_OFF[s*22 +: 22];
          end
        end else if (!m_dph) begin
          if (a_ack) begin m_dph = 1'b1; m_burst = 1'b0; end
        end else if (a_rdy && (a_dst || m_burst)) begin
          m_data[m_slot]  = m_addr[m_slot][0] ? a_read[15:8] : a_read[7:0];
          m_valid[m_slot] = 1'b1;
          m_busy = 1'b0;
        end else if (a_dst) begin
          m_burst = 1'b1;
        end
`ifndef JTFRAME_ROM_CACHE_EN
        for (int i = 0; i < 3; i++)
          if (!a_cs[i]) m_valid[i] = 1'b0;
`endif
      end
    end
  end

  // Compare process and request-pulse counter, both on the falling edge.
  int   req_cnt = 0;
  logic req_q = 1'b0;
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("cyc_ok", a_ok[i], m_ok(i));
      check("cyc_dout", a_dout[i*8 +: 8], m_data[i]);
    end
    check("cyc_req", a_req, m_busy && !m_dph);
    if (m_busy && !m_dph) check("cyc_sdram_addr", a_saddr, m_word);
    if (a_req && !req_q) req_cnt++;
    req_q = a_req;
  end

  logic [21:0] last_word;
  int          base;

  task automatic set_a(input int i, input logic [17:0] v);
    a_addr[i*18 +: 18] = v;
  endtask

  task automatic wait_req_a();
    for (int n = 0; n < 50 && !a_req; n++) tick();
    check("req_seen", a_req, 1'b1);
  endtask

  task automatic serve(input int ack_dly);
    wait_req_a();
    last_word = a_saddr;
    repeat (ack_dly) tick();
    a_ack = 1'b1; tick(); a_ack = 1'b0; tick();
    a_dst = 1'b1; a_rdy = 1'b1; a_read = pat(last_word); tick();
    a_dst = 1'b0; a_rdy = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    a_cs = '0; a_addr = '0; a_ack = 0; a_dst = 0; a_rdy = 0; a_read = '0;
    b_cs = '0; b_addr = '0; b_ack = 0; b_dst = 0; b_rdy = 0; b_read = '0;
    repeat (3) tick();
    check("rst_req", a_req, 1'b0);
    check("rst_saddr", a_saddr, 22'h0);
    check("rst_ok", a_ok, 3'b000);
    check("rst_dout", a_dout, 24'h0);
    check("rst_b_dout", b_dout, 64'h0);
    rst_n = 1'b1; tick();

    // Odd byte address: high byte of word 2.
    base = req_cnt;
    set_a(0, 18'h00005); a_cs[0] = 1'b1;
    serve(2);
    check("t1_word", last_word, 22'h000002);
    check("t1_dout", a_dout[7:0], 8'hA5);
    check("t1_ok", a_ok[0], 1'b1);
    repeat (4) tick();
    check("t1_reqs", req_cnt - base, 1);

    // Even byte address: low byte of word 3.
    set_a(0, 18'h00006);
    serve(1);
    check("t2_word", last_word, 22'h000003);
    check("t2_dout", a_dout[7:0], 8'h59);

    // Slot 2 offset wraps modulo 2^22.
    set_a(2, 18'h00040); a_cs[2] = 1'b1;
    serve(1);
    check("wrap_word", last_word, 22'h000010);
    check("wrap_dout", a_dout[23:16], 8'h4A);

    // Slots 0 and 2 pending together: index order.
    a_cs = '0; tick();
    set_a(0, 18'h00100); set_a(2, 18'h00102); a_cs = 3'b101;
    base = req_cnt;
    serve(1);
    check("pri_first", last_word, 22'h000080);
    serve(1);
    check("pri_second", last_word, 22'h000071);
    check("pri_ok", a_ok, 3'b101);
    check("pri_dout0", a_dout[7:0], 8'hDA);
    check("pri_dout2", a_dout[23:16], 8'h2B);
    check("pri_reqs", req_cnt - base, 2);

    // Address changes while data is pending: old result gives no ok, refetch.
    a_cs = '0; tick();
    set_a(1, 18'h00200); a_cs[1] = 1'b1;
    base = req_cnt;
    wait_req_a();
    check("chg_word0", a_saddr, 22'h000140);
    tick();
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    set_a(1, 18'h00202); tick();
    a_dst = 1'b1; a_rdy = 1'b1; a_read = 16'hBEEF; tick();
    a_dst = 1'b0; a_rdy = 1'b0;
    check("chg_no_ok", a_ok[1], 1'b0);
    serve(1);
    check("chg_word1", last_word, 22'h000141);
    check("chg_ok", a_ok[1], 1'b1);
    check("chg_dout", a_dout[15:8], 8'h1B);
    check("chg_reqs", req_cnt - base, 2);

    // cs dropped and re-asserted at the same address.
    a_cs[1] = 1'b0; repeat (2) tick();
    base = req_cnt;
    a_cs[1] = 1'b1; #1;
`ifdef JTFRAME_ROM_CACHE_EN
    check("reassert_ok", a_ok[1], 1'b1);
    repeat (5) tick();
    check("reassert_reqs", req_cnt - base, 0);
`else
    check("reassert_ok", a_ok[1], 1'b0);
    serve(1);
    check("reassert_reqs", req_cnt - base, 1);
    check("reassert_ok2", a_ok[1], 1'b1);
`endif

    // 32-bit client: two words, low half first, offset on slot 1.
    b_addr[35:18] = 18'h00010; b_cs = 2'b10;
    for (int n = 0; n < 50 && !b_req; n++) tick();
    check("b_req_seen", b_req, 1'b1);
    check("b_word", b_saddr, 22'h100020);
    tick();
    b_ack = 1'b1; tick(); b_ack = 1'b0; tick();
    b_dst = 1'b1; b_rdy = 1'b1; b_read = 16'h1234; tick();
    b_dst = 1'b0; b_read = 16'h5678;
    check("b_mid_ok", b_ok[1], 1'b0);
    check("b_mid_dout", b_dout[63:32], 32'h0);
    tick(); b_rdy = 1'b0;
    check("b_dout", b_dout[63:32], 32'h56781234);
    check("b_ok", b_ok[1], 1'b1);

    // Reset during WAIT_ACK abandons the fetch; late data is ignored.
    base = req_cnt;
    set_a(0, 18'h00300); a_cs = 3'b001;
    wait_req_a();
    tick();
    rst_n = 1'b0; #1;
    check("rmid_req", a_req, 1'b0);
    check("rmid_ok", a_ok, 3'b000);
    a_cs = '0; tick();
    rst_n = 1'b1; tick();
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    a_dst = 1'b1; a_rdy = 1'b1; a_read = 16'h1357; tick();
    a_dst = 1'b0; a_rdy = 1'b0; tick();
    check("rmid_dout", a_dout, 24'h0);
    check("rmid_req_after", a_req, 1'b0);
    check("rmid_reqs", req_cnt - base, 1);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
